// File: rtl/vga_draw_pkg.sv
// rtl/vga_draw_pkg.sv - shared types and defaults for the VGA draw path
package vga_draw_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEF_H_RES   = 320;
    localparam int DEF_V_RES   = 240;
    localparam int DEF_X_W     = 9;
    localparam int DEF_Y_W     = 8;
    localparam int DEF_COLOR_W = 3;
    localparam int CLIP_W      = 16;

    function automatic logic [CLIP_W-1:0] sat_inc(input logic [CLIP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// rtl/vga_draw_arbiter_if.sv - draw-engine clients to VGA pixel port bundle
interface vga_draw_arbiter_if
    import vga_draw_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOR_W     = DEF_COLOR_W
) ();
    logic [NUM_CLIENTS-1:0]         req;
    logic [NUM_CLIENTS-1:0]         done;
    logic [NUM_CLIENTS-1:0]         pix_valid;
    logic [NUM_CLIENTS*X_W-1:0]     x_in;
    logic [NUM_CLIENTS*Y_W-1:0]     y_in;
    logic [NUM_CLIENTS*COLOR_W-1:0] color_in;
    logic [NUM_CLIENTS-1:0]         grant;
    logic                           busy;
    logic                           plot;
    logic [X_W-1:0]                 X;
    logic [Y_W-1:0]                 Y;
    logic [COLOR_W-1:0]             color;
    logic [CLIP_W-1:0]              clip_count;

    modport master (
        output req, done, pix_valid, x_in, y_in, color_in,
        input  grant, busy, plot, X, Y, color, clip_count
    );

    modport slave (
        input  req, done, pix_valid, x_in, y_in, color_in,
        output grant, busy, plot, X, Y, color, clip_count
    );
endinterface

// File: rtl/draw_priority_picker.sv
// rtl/draw_priority_picker.sv - combinational winner selection, fixed or round-robin
module draw_priority_picker
    import vga_draw_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int RR_MODE     = ARB_FIXED,
    parameter int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       last_owner,
    output logic [NUM_CLIENTS-1:0] win_onehot,
    output logic [IDX_W-1:0]       win_idx
);
    int   k;
    logic found;

    // Round-robin starts the scan just past the previous owner and wraps.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        k          = 0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            if (RR_MODE == ARB_RR) begin
                k = (int'(last_owner) + 1 + j) % NUM_CLIENTS;
            end else begin
                k = j;
            end
            if (!found && req[k]) begin
                found         = 1'b1;
                win_idx       = IDX_W'(k);
                win_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - exclusive-ownership arbiter onto the VGA pixel-write port
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int RR_MODE     = ARB_FIXED
) (
    input logic               clock,
    input logic               reset,
    vga_draw_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    arb_state_e             state;
    arb_state_e             state_next;
    logic [NUM_CLIENTS-1:0] grant_q;
    logic [NUM_CLIENTS-1:0] grant_next;
    logic [IDX_W-1:0]       last_owner;
    logic [NUM_CLIENTS-1:0] win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   load_owner;
    logic                   accept_pix;
    logic                   owner_req;
    logic                   owner_done;
    logic                   owner_pix;
    logic                   release_owner;
    logic                   in_bounds;
    logic [X_W-1:0]         sel_x;
    logic [Y_W-1:0]         sel_y;
    logic [COLOR_W-1:0]     sel_color;
    logic                   plot_q;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;
    logic [COLOR_W-1:0]     color_q;
    logic [CLIP_W-1:0]      clip_q;

    draw_priority_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .RR_MODE     (RR_MODE),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (bus.req),
        .last_owner (last_owner),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // While OWNED, last_owner is the current owner, so it doubles as the mux select.
    always_comb begin
        owner_req     = bus.req[last_owner];
        owner_done    = bus.done[last_owner];
        owner_pix     = bus.pix_valid[last_owner];
        sel_x         = bus.x_in[int'(last_owner)*X_W +: X_W];
        sel_y         = bus.y_in[int'(last_owner)*Y_W +: Y_W];
        sel_color     = bus.color_in[int'(last_owner)*COLOR_W +: COLOR_W];
        release_owner = owner_done || !owner_req;
        in_bounds     = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (|bus.req)     state_next = ST_OWNED;
            ST_OWNED: if (release_owner) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_next = '0;
        load_owner = 1'b0;
        accept_pix = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_next = win_onehot;
                    load_owner = 1'b1;
                end
            end
            ST_OWNED: begin
                // The owner's last pixel is taken even in its release cycle.
                accept_pix = owner_pix;
                grant_next = release_owner ? '0 : grant_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q    <= '0;
            last_owner <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            grant_q <= grant_next;
            if (load_owner) begin
                last_owner <= win_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            clip_q  <= '0;
        end else begin
            plot_q <= accept_pix && in_bounds;
            if (accept_pix && in_bounds) begin
                x_q     <= sel_x;
                y_q     <= sel_y;
                color_q <= sel_color;
            end
            if (accept_pix && !in_bounds) begin
                clip_q <= sat_inc(clip_q);
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = (state == ST_OWNED);
    assign bus.plot       = plot_q;
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.color      = color_q;
    assign bus.clip_count = clip_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - fixed-priority and round-robin arbiters against a reference model
module tb_vga_draw_arbiter;
    localparam int NC = 4;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;
    localparam int HR = 320;
    localparam int VR = 240;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vga_draw_arbiter_if #(.NUM_CLIENTS(NC), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus_fp ();
    vga_draw_arbiter_if #(.NUM_CLIENTS(NC), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus_rr ();

    vga_draw_arbiter #(.NUM_CLIENTS(NC), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
                       .H_RES(HR), .V_RES(VR), .RR_MODE(0)) dut_fp (
        .clock (clock), .reset (reset), .bus (bus_fp.slave));
    vga_draw_arbiter #(.NUM_CLIENTS(NC), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
                       .H_RES(HR), .V_RES(VR), .RR_MODE(1)) dut_rr (
        .clock (clock), .reset (reset), .bus (bus_rr.slave));

    logic [NC-1:0] req, done, pv;
    int            xs [NC];
    int            ys [NC];
    int            cs [NC];

    // Reference: index 0 = fixed priority, 1 = round-robin; owner -1 means nobody
    int m_owner [2];
    int m_last  [2];
    int m_plot  [2];
    int m_x     [2];
    int m_y     [2];
    int m_c     [2];
    int m_clip  [2];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus_fp.req = req;  bus_rr.req = req;
        bus_fp.done = done; bus_rr.done = done;
        bus_fp.pix_valid = pv; bus_rr.pix_valid = pv;
        for (int i = 0; i < NC; i++) begin
            bus_fp.x_in[i*XW +: XW]     = XW'(xs[i]);
            bus_rr.x_in[i*XW +: XW]     = XW'(xs[i]);
            bus_fp.y_in[i*YW +: YW]     = YW'(ys[i]);
            bus_rr.y_in[i*YW +: YW]     = YW'(ys[i]);
            bus_fp.color_in[i*CW +: CW] = CW'(cs[i]);
            bus_rr.color_in[i*CW +: CW] = CW'(cs[i]);
        end
    endtask

    task automatic model_tick();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_owner[m] = -1; m_last[m] = NC - 1; m_plot[m] = 0;
                m_x[m] = 0; m_y[m] = 0; m_c[m] = 0; m_clip[m] = 0;
            end else if (m_owner[m] < 0) begin
                m_plot[m] = 0;
                for (int j = 0; j < NC; j++) begin
                    int k;
                    k = (m == 1) ? (m_last[m] + 1 + j) % NC : j;
                    if (m_owner[m] < 0 && req[k]) begin
                        m_owner[m] = k;
                        m_last[m]  = k;
                    end
                end
            end else begin
                int o;
                o = m_owner[m];
                m_plot[m] = 0;
                if (pv[o]) begin
                    if (xs[o] < HR && ys[o] < VR) begin
                        m_plot[m] = 1; m_x[m] = xs[o]; m_y[m] = ys[o]; m_c[m] = cs[o];
                    end else if (m_clip[m] < 65535) begin
                        m_clip[m]++;
                    end
                end
                if (done[o] || !req[o]) m_owner[m] = -1;
            end
        end
    endtask

    task automatic compare_one(input string p, input int m, input logic [NC-1:0] g, input logic b,
                               input logic pl, input logic [XW-1:0] x, input logic [YW-1:0] y,
                               input logic [CW-1:0] c, input logic [15:0] cl);
        check_eq({p, "_grant"}, 32'(g), (m_owner[m] < 0) ? 32'd0 : 32'd1 << m_owner[m]);
        check_eq({p, "_busy"},  32'(b), (m_owner[m] < 0) ? 32'd0 : 32'd1);
        check_eq({p, "_plot"},  32'(pl), 32'(m_plot[m]));
        check_eq({p, "_x"},     32'(x), 32'(m_x[m]));
        check_eq({p, "_y"},     32'(y), 32'(m_y[m]));
        check_eq({p, "_color"}, 32'(c), 32'(m_c[m]));
        check_eq({p, "_clip"},  32'(cl), 32'(m_clip[m]));
    endtask

    task automatic step();
        apply();
        @(posedge clock);
        model_tick();
        #1;
        compare_one("fp", 0, bus_fp.grant, bus_fp.busy, bus_fp.plot, bus_fp.X, bus_fp.Y,
                    bus_fp.color, bus_fp.clip_count);
        compare_one("rr", 1, bus_rr.grant, bus_rr.busy, bus_rr.plot, bus_rr.X, bus_rr.Y,
                    bus_rr.color, bus_rr.clip_count);
    endtask

    task automatic quiet();
        req = '0; done = '0; pv = '0;
        for (int i = 0; i < NC; i++) begin xs[i] = 0; ys[i] = 0; cs[i] = 0; end
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int plots;

    initial begin
        quiet();
        do_reset();
        check_eq("rst_grant", 32'(bus_fp.grant), 32'd0);
        check_eq("rst_plot",  32'(bus_fp.plot), 32'd0);
        check_eq("rst_x",     32'(bus_rr.X), 32'd0);
        check_eq("rst_clip",  32'(bus_rr.clip_count), 32'd0);

        // single client: grant, one pixel, done
        req = 4'b0100; step();
        check_eq("single_grant", 32'(bus_fp.grant), 32'h4);
        pv = 4'b0100; xs[2] = 10; ys[2] = 20; cs[2] = 5; step();
        check_eq("single_plot", 32'(bus_fp.plot), 32'd1);
        check_eq("single_x", 32'(bus_fp.X), 32'd10);
        check_eq("single_y", 32'(bus_fp.Y), 32'd20);
        check_eq("single_color", 32'(bus_fp.color), 32'd5);
        pv = '0; done = 4'b0100; step();
        check_eq("single_release", 32'(bus_fp.grant), 32'd0);
        done = '0; req = '0; step();

        // fixed-priority contention: client 1 keeps winning over client 3
        req = 4'b1010; step();
        check_eq("fp_contend", 32'(bus_fp.grant), 32'h2);
        done = 4'b0010; step();
        check_eq("fp_bubble", 32'(bus_fp.grant), 32'd0);
        done = '0; step();
        check_eq("fp_regrant", 32'(bus_fp.grant), 32'h2);
        req = '0; step(); step();

        // round-robin fairness over five 3-pixel bursts
        do_reset();
        plots = 0;
        for (int b = 0; b < 5; b++) begin
            req = 4'b1111; done = '0; pv = '0; step();
            check_eq("rr_order", 32'(bus_rr.grant), 32'd1 << (b % 4));
            for (int p = 0; p < 3; p++) begin
                pv = 4'b1111;
                for (int i = 0; i < NC; i++) begin
                    xs[i] = b * 10 + p; ys[i] = i; cs[i] = p;
                end
                step();
                if (b < 4 && bus_rr.plot) plots++;
            end
            pv = '0; done = 4'b1111; step();
            if (b < 4 && bus_rr.plot) plots++;
            check_eq("rr_bubble", 32'(bus_rr.grant), 32'd0);
        end
        check_eq("rr_plots", 32'(plots), 32'd12);
        done = '0; req = '0; step();

        // clipping at the visible edges, then saturation
        do_reset();
        req = 4'b0001; step();
        plots = 0;
        for (int i = 0; i < 4; i++) begin
            pv = 4'b0001;
            xs[0] = (i == 0) ? 319 : (i == 1) ? 320 : (i == 2) ? 0 : 511;
            ys[0] = (i == 0) ? 239 : (i == 1) ? 0 : (i == 2) ? 240 : 255;
            cs[0] = i + 1;
            step();
            if (bus_fp.plot) plots++;
        end
        pv = '0; step();
        check_eq("clip_plots", 32'(plots), 32'd1);
        check_eq("clip_count", 32'(bus_fp.clip_count), 32'd3);
        pv = 4'b0001; xs[0] = 400; ys[0] = 10;
        for (int i = 0; i < 65540; i++) step();
        check_eq("clip_sat", 32'(bus_fp.clip_count), 32'hFFFF);
        check_eq("clip_hold_x", 32'(bus_fp.X), 32'd319);

        // non-owner strobes ignored, implicit release with last pixel
        do_reset();
        req = 4'b0001; step();
        req = 4'b0101; pv = 4'b0100; done = 4'b0100; xs[2] = 5; ys[2] = 5; step();
        check_eq("nonowner_plot", 32'(bus_fp.plot), 32'd0);
        check_eq("nonowner_grant", 32'(bus_fp.grant), 32'h1);
        req = 4'b0000; done = '0; pv = 4'b0001; xs[0] = 7; ys[0] = 8; cs[0] = 6; step();
        check_eq("drop_plot", 32'(bus_fp.plot), 32'd1);
        check_eq("drop_x", 32'(bus_fp.X), 32'd7);
        check_eq("drop_grant", 32'(bus_fp.grant), 32'd0);
        pv = '0; step();

        // reset with a pixel in flight, then round-robin restarts at client 0
        req = 4'b0010; step();
        pv = 4'b0010; xs[1] = 30; ys[1] = 40; step();
        reset = 1'b1; step();
        check_eq("midrst_plot", 32'(bus_rr.plot), 32'd0);
        check_eq("midrst_grant", 32'(bus_rr.grant), 32'd0);
        reset = 1'b0; pv = '0; req = 4'b1111; step();
        check_eq("midrst_rr_first", 32'(bus_rr.grant), 32'h1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                done[i] = ($urandom_range(0, 9) == 0);
                pv[i]   = ($urandom_range(0, 1) == 1);
                xs[i]   = ($urandom_range(0, 1) == 1) ? $urandom_range(300, 340) : $urandom_range(0, 511);
                ys[i]   = ($urandom_range(0, 1) == 1) ? $urandom_range(225, 255) : $urandom_range(0, 255);
                cs[i]   = $urandom_range(0, 7);
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
